nr_divider: RTL

//  Sequential unsigned non-restoring divider; the inverse companion to the Booth multiplier.

---
 rtl/nr_div_pkg.sv | 21 ++
 rtl/nr_divider_if.sv | 31 +++
 rtl/nr_div_datapath.sv | 73 +++++++
 rtl/nr_divider.sv | 98 +++++++++
 4 files changed

// File: rtl/nr_div_pkg.sv
// ============================================================================
//  Module   : nr_div_pkg
//  Brief    : Shared state encoding and default width for the divider.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package nr_div_pkg;

    localparam int c_DEF_WIDTH = 16;

    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_ITER = 2'd1;
    localparam state_t c_FIX  = 2'd2;
    localparam state_t c_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/nr_divider_if.sv
// ============================================================================
//  Module   : nr_divider_if
//  Brief    : Start/done request bus between a requester and the divider.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface nr_divider_if #(
    parameter int WIDTH = nr_div_pkg::c_DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/nr_div_datapath.sv
// ============================================================================
//  Module   : nr_div_datapath
//  Brief    : A/Q/M registers, (WIDTH+1)-bit add/sub unit and iteration counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module nr_div_datapath
    import nr_div_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_load,
    input  wire logic             i_iter,
    input  wire logic             i_fix,
    input  wire logic [WIDTH-1:0] i_dividend,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic                  o_a_sign,
    output logic                  o_cnt_last,
    output logic [WIDTH-1:0]      o_q,
    output logic [WIDTH-1:0]      o_a_low,
    output logic [WIDTH-1:0]      o_a_fixed_low
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_step;
    logic [WIDTH:0]   w_fix;

    assign w_m_ext = {1'b0, r_m};
    assign w_shift = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    // Operation is chosen by the sign of A before the shift.
    assign w_step  = r_a[WIDTH] ? (w_shift + w_m_ext) : (w_shift - w_m_ext);
    assign w_fix   = r_a + w_m_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_a   <= '0;
            r_q   <= i_dividend;
            r_m   <= i_divisor;
            r_cnt <= CW'(WIDTH);
        end else if (i_iter) begin
            r_a   <= w_step;
            r_q   <= {r_q[WIDTH-2:0], ~w_step[WIDTH]};
            r_cnt <= r_cnt - CW'(1);
        end else if (i_fix && r_a[WIDTH]) begin
            r_a   <= w_fix;
        end
    end

    assign o_a_sign      = r_a[WIDTH];
    assign o_cnt_last    = (r_cnt == CW'(1));
    assign o_q           = r_q;
    assign o_a_low       = r_a[WIDTH-1:0];
    assign o_a_fixed_low = w_fix[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/nr_divider.sv
// ============================================================================
//  Module   : nr_divider
//  Brief    : Sequential unsigned non-restoring divider, controller and results.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module nr_divider
    import nr_div_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    nr_divider_if.slave bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dz;

    logic             w_load;
    logic             w_a_sign;
    logic             w_cnt_last;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_a_low;
    logic [WIDTH-1:0] w_a_fixed_low;
    logic [WIDTH-1:0] w_rem_final;

    assign w_load      = (r_state == c_IDLE) && bus.start;
    // Results load on the FIX->DONE edge, so the correction is applied here too.
    assign w_rem_final = w_a_sign ? w_a_fixed_low : w_a_low;

    nr_div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_load),
        .i_iter        (r_state == c_ITER),
        .i_fix         (r_state == c_FIX),
        .i_dividend    (bus.dividend),
        .i_divisor     (bus.divisor),
        .o_a_sign      (w_a_sign),
        .o_cnt_last    (w_cnt_last),
        .o_q           (w_q),
        .o_a_low       (w_a_low),
        .o_a_fixed_low (w_a_fixed_low)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dz        <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            r_state     <= c_DONE;
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                            r_dz        <= 1'b1;
                        end else begin
                            r_state     <= c_ITER;
                        end
                    end
                end
                c_ITER: begin
                    if (w_cnt_last) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    r_state     <= c_DONE;
                    r_quotient  <= w_q;
                    r_remainder <= w_rem_final;
                    r_dz        <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = (r_state != c_IDLE);
    assign bus.done        = (r_state == c_DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dz;

endmodule

`default_nettype wire
